// File: rtl/fifo_drain_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_drain_pkg: shared state encoding and widths for fifo_drain_serializer.
// Rev 1.0
// ----------------------------------------------------------------------------
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } drain_state_t;

  localparam int COUNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/drain_shift_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// drain_shift_reg: holds one FIFO word and presents the OUT_WIDTH beat picked by beat_idx.
// Rev 1.0
// ----------------------------------------------------------------------------
module drain_shift_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [DATA_WIDTH-1:0]    load_data,
  input  logic [((DATA_WIDTH/OUT_WIDTH) > 1 ? $clog2(DATA_WIDTH/OUT_WIDTH) : 1)-1:0] beat_idx,
  output logic [OUT_WIDTH-1:0]     beat_data
);

  localparam int BEATS = DATA_WIDTH / OUT_WIDTH;

  logic [DATA_WIDTH-1:0] word;
  logic [OUT_WIDTH-1:0]  slices [BEATS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else if (load) begin
      word <= load_data;
    end
  end

  // slices[] is always in emission order, so the mux below is order-agnostic
  for (genvar g = 0; g < BEATS; g++) begin : g_slice
    if (LSB_FIRST) begin : g_lsb
      assign slices[g] = word[g*OUT_WIDTH +: OUT_WIDTH];
    end else begin : g_msb
      assign slices[g] = word[(BEATS-1-g)*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign beat_data = slices[beat_idx];

endmodule
`default_nettype wire

// File: rtl/fifo_drain_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_drain_serializer: pops FIFO words and emits them as OUT_WIDTH valid/ready beats.
// Define FIFO_DRAIN_STATS_EN to add the word_count_out completed-word counter.
// Rev 1.0
// ----------------------------------------------------------------------------
module fifo_drain_serializer
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  fifo_empty_in,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_valid_in,
  output logic                  fifo_deq_out,
  output logic [OUT_WIDTH-1:0]  m_data_out,
  output logic                  m_valid_out,
  output logic                  m_last_out,
  input  logic                  m_ready_in,
  output logic                  busy_out,
  output logic                  err_out
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [COUNT_W-1:0]    word_count_out
`endif
);

  localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

  drain_state_t         state;
  drain_state_t         next_state;
  logic [IDX_W-1:0]     beat;
  logic [IDX_W-1:0]     next_beat;
  logic                 load;
  logic                 err_set;
  logic [OUT_WIDTH-1:0] beat_data;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= IDLE;
      beat    <= '0;
      err_out <= 1'b0;
    end else begin
      state <= next_state;
      beat  <= next_beat;
      if (err_set) begin
        err_out <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state   = state;
    next_beat    = beat;
    fifo_deq_out = 1'b0;
    load         = 1'b0;
    // a FIFO response is only legal in the cycle after our deq
    err_set      = fifo_valid_in && (state != REQ);
    unique case (state)
      IDLE: begin
        if (!fifo_empty_in) begin
          fifo_deq_out = 1'b1;
          next_state   = REQ;
        end
      end
      REQ: begin
        if (fifo_valid_in) begin
          load       = 1'b1;
          next_beat  = '0;
          next_state = SEND;
        end else begin
          err_set    = 1'b1;
          next_state = IDLE;
        end
      end
      SEND: begin
        if (m_ready_in) begin
          if (beat == LAST_BEAT) begin
            next_beat = '0;
            // chain straight into the next pop to keep a single bubble per word
            if (!fifo_empty_in) begin
              fifo_deq_out = 1'b1;
              next_state   = REQ;
            end else begin
              next_state   = IDLE;
            end
          end else begin
            next_beat = beat + 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  drain_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .LSB_FIRST  (LSB_FIRST)
  ) u_shift (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .load      (load),
    .load_data (fifo_data_in),
    .beat_idx  (beat),
    .beat_data (beat_data)
  );

  assign m_valid_out = (state == SEND);
  assign m_last_out  = (state == SEND) && (beat == LAST_BEAT);
  assign m_data_out  = (state == SEND) ? beat_data : '0;
  assign busy_out    = (state != IDLE);

`ifdef FIFO_DRAIN_STATS_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      word_count_out <= '0;
    end else if (m_valid_out && m_ready_in && m_last_out) begin
      word_count_out <= word_count_out + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fifo_drain_serializer: FIFO model feeding LSB-first and MSB-first serializers.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fifo_drain_serializer;

  localparam int BUDGET = 60;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_l;   // expected beats, first beat in the top byte
    logic [31:0] exp_m;
    int          stall_beat;
    int          stall_cycles;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_valid;
  logic        model_valid;
  logic        suppress_valid;
  logic        inj_valid;
  logic        enq_en;
  logic [31:0] enq_data;
  logic        ready;
  logic        deq_l, deq_m, valid_l, valid_m, last_l, last_m, busy_l, busy_m, err_l, err_m;
  logic [7:0]  data_l, data_m;
`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0] wc_l, wc_m;
`endif

  logic [31:0] mem [16];
  logic [3:0]  wr_ptr, rd_ptr;
  int          cnt;

  int    checks = 0;
  int    errors = 0;
  int    deq_total = 0;
  beat_t sb_l[$];
  beat_t sb_m[$];
  logic  hold_l, hold_m, hold_ll, hold_lm;
  logic [7:0] hold_dl, hold_dm;
  vec_t  vec [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Team-FIFO stand-in: registered empty, data/valid one cycle after deq
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= 0;
      model_valid <= 1'b0;
      fifo_data   <= '0;
    end else begin
      if (enq_en) begin
        mem[wr_ptr] <= enq_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      model_valid <= deq_l && (cnt != 0);
      if (deq_l && (cnt != 0)) begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      cnt <= cnt + (enq_en ? 1 : 0) - ((deq_l && (cnt != 0)) ? 1 : 0);
    end
  end

  assign fifo_empty = (cnt == 0);
  assign fifo_valid = (model_valid && !suppress_valid) || inj_valid;

  fifo_drain_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
    .clk_in(clk), .rst_n_in(rst_n), .fifo_empty_in(fifo_empty), .fifo_data_in(fifo_data),
    .fifo_valid_in(fifo_valid), .fifo_deq_out(deq_l), .m_data_out(data_l), .m_valid_out(valid_l),
    .m_last_out(last_l), .m_ready_in(ready), .busy_out(busy_l), .err_out(err_l)
`ifdef FIFO_DRAIN_STATS_EN
    , .word_count_out(wc_l)
`endif
  );

  fifo_drain_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
    .clk_in(clk), .rst_n_in(rst_n), .fifo_empty_in(fifo_empty), .fifo_data_in(fifo_data),
    .fifo_valid_in(fifo_valid), .fifo_deq_out(deq_m), .m_data_out(data_m), .m_valid_out(valid_m),
    .m_last_out(last_m), .m_ready_in(ready), .busy_out(busy_m), .err_out(err_m)
`ifdef FIFO_DRAIN_STATS_EN
    , .word_count_out(wc_m)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int b = 0; b < 4; b++) begin
      sb_l.push_back('{t[8*b +: 8], b == 3});
      sb_m.push_back('{t[8*(3-b) +: 8], b == 3});
    end
  endtask

  task automatic clear_track();
    hold_l = 1'b0;
    hold_m = 1'b0;
    sb_l.delete();
    sb_m.delete();
  endtask

  // Called at each negedge with ready already set for the coming posedge
  task automatic monitor();
    beat_t e;
    if (deq_l) deq_total++;
    if (hold_l) begin
      chk("l_hold_valid", valid_l, 1);
      chk("l_hold_data", data_l, hold_dl);
      chk("l_hold_last", last_l, hold_ll);
    end
    if (hold_m) begin
      chk("m_hold_valid", valid_m, 1);
      chk("m_hold_data", data_m, hold_dm);
      chk("m_hold_last", last_m, hold_lm);
    end
    if (valid_l && ready) begin
      chk("l_beat_expected", sb_l.size() != 0, 1);
      if (sb_l.size() != 0) begin
        e = sb_l.pop_front();
        chk("l_data", data_l, e.data);
        chk("l_last", last_l, e.last);
      end
    end
    if (valid_m && ready) begin
      chk("m_beat_expected", sb_m.size() != 0, 1);
      if (sb_m.size() != 0) begin
        e = sb_m.pop_front();
        chk("m_data", data_m, e.data);
        chk("m_last", last_m, e.last);
      end
    end
    hold_l  = valid_l && !ready;
    hold_dl = data_l;
    hold_ll = last_l;
    hold_m  = valid_m && !ready;
    hold_dm = data_m;
    hold_lm = last_m;
  endtask

  task automatic enq(input logic [31:0] w);
    enq_en   = 1'b1;
    enq_data = w;
    monitor();
    tick();
    enq_en   = 1'b0;
  endtask

  task automatic run_drain(input int s_beat, input int s_cyc, output int cyc,
                           output int f_deq, output int f_val, output int vcyc);
    int stalls;
    int cur;
    stalls = 0;
    cyc = 0; f_deq = -1; f_val = -1; vcyc = 0;
    while ((sb_l.size() != 0 || busy_l) && cyc < BUDGET) begin
      cur = (4 - (sb_l.size() % 4)) % 4;
      if (valid_l && cur == s_beat && stalls < s_cyc) begin
        ready = 1'b0;
        stalls++;
      end else begin
        ready = 1'b1;
      end
      if (deq_l && f_deq < 0) f_deq = cyc;
      if (valid_l) begin
        vcyc++;
        if (f_val < 0) f_val = cyc;
      end
      monitor();
      tick();
      cyc++;
    end
    ready = 1'b1;
    chk("drain_in_budget", cyc < BUDGET, 1);
    chk("l_scoreboard_empty", sb_l.size(), 0);
    chk("m_scoreboard_empty", sb_m.size(), 0);
    if (cyc >= BUDGET) clear_track();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_l_data"}, data_l, 0);
    chk({tag, "_l_valid"}, valid_l, 0);
    chk({tag, "_l_last"}, last_l, 0);
    chk({tag, "_l_busy"}, busy_l, 0);
    chk({tag, "_l_err"}, err_l, 0);
    chk({tag, "_l_deq"}, deq_l, 0);
    chk({tag, "_m_data"}, data_m, 0);
    chk({tag, "_m_valid"}, valid_m, 0);
    chk({tag, "_m_last"}, last_m, 0);
    chk({tag, "_m_busy"}, busy_m, 0);
    chk({tag, "_m_err"}, err_m, 0);
    chk({tag, "_m_deq"}, deq_m, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_all_zero(tag);
    clear_track();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc, f_deq, f_val, vcyc, d0, k;

    vec[0] = '{32'hA1B2C3D4, 32'hD4C3B2A1, 32'hA1B2C3D4, -1, 0};
    vec[1] = '{32'h11223344, 32'h44332211, 32'h11223344, -1, 0};
    vec[2] = '{32'hA1B2C3D4, 32'hD4C3B2A1, 32'hA1B2C3D4,  2, 3};
    vec[3] = '{32'h00FF8001, 32'h0180FF00, 32'h00FF8001,  0, 1};
    vec[4] = '{32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEF,  3, 2};

    rst_n = 1'b0; enq_en = 1'b0; enq_data = '0; ready = 1'b0;
    suppress_valid = 1'b0; inj_valid = 1'b0;
    clear_track();
    hold_dl = '0; hold_dm = '0; hold_ll = 1'b0; hold_lm = 1'b0;

    @(negedge clk);
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < 4; b++) begin
        sb_l.push_back('{vec[i].exp_l[31-8*b -: 8], b == 3});
        sb_m.push_back('{vec[i].exp_m[31-8*b -: 8], b == 3});
      end
      d0 = deq_total;
      enq(vec[i].word);
      run_drain(vec[i].stall_beat, vec[i].stall_cycles, cyc, f_deq, f_val, vcyc);
      chk($sformatf("v%0d_latency", i), f_val - f_deq, 2);
      chk($sformatf("v%0d_valid_cycles", i), vcyc, 4 + vec[i].stall_cycles);
      chk($sformatf("v%0d_busy_drop", i), cyc - f_val, 4 + vec[i].stall_cycles);
      chk($sformatf("v%0d_deq_pulses", i), deq_total - d0, 1);
      tick();
    end

    // Back-to-back words: one bubble between them, two deq pulses
    push_word(32'h11223344);
    push_word(32'h55667788);
    d0 = deq_total;
    enq(32'h11223344);
    enq(32'h55667788);
    run_drain(-1, 0, cyc, f_deq, f_val, vcyc);
    chk("b2b_valid_cycles", vcyc, 8);
    chk("b2b_span", cyc - f_val, 9);
    chk("b2b_deq_pulses", deq_total - d0, 2);
    tick();

    // Empty race: deq answered without valid
    suppress_valid = 1'b1;
    enq(32'hCAFEF00D);
    chk("race_deq", deq_l, 1);
    monitor();
    tick();
    chk("race_req_busy", busy_l, 1);
    monitor();
    tick();
    suppress_valid = 1'b0;
    chk("race_l_err", err_l, 1);
    chk("race_m_err", err_m, 1);
    chk("race_l_valid", valid_l, 0);
    chk("race_l_busy", busy_l, 0);
    monitor();
    tick();
    chk("race_err_sticky", err_l, 1);
    do_reset("race_clear");

    // Stray valid while idle
    tick();
    inj_valid = 1'b1;
    monitor();
    tick();
    inj_valid = 1'b0;
    chk("stray_l_err", err_l, 1);
    chk("stray_m_err", err_m, 1);
    chk("stray_l_busy", busy_l, 0);
    chk("stray_l_valid", valid_l, 0);
    do_reset("stray_clear");

    // Asynchronous reset while beat 1 is on the bus
    push_word(32'hA1B2C3D4);
    enq(32'hA1B2C3D4);
    k = 0;
    while (!(valid_l && sb_l.size() == 3) && k < 20) begin
      monitor();
      tick();
      k++;
    end
    chk("midrst_reached", k < 20, 1);
    chk("midrst_beat1_l", data_l, 8'hC3);
    chk("midrst_beat1_m", data_m, 8'hB2);
    #1;
    do_reset("midrst");
    for (int j = 0; j < 4; j++) begin
      monitor();
      tick();
    end
    chk("midrst_idle_busy", busy_l, 0);
    chk("midrst_idle_valid", valid_l, 0);
    chk("midrst_idle_deq", deq_l, 0);
    chk("midrst_idle_err", err_l, 0);

`ifdef FIFO_DRAIN_STATS_EN
    chk("stats_reset", wc_l, 0);
    push_word(32'h01020304);
    push_word(32'h05060708);
    push_word(32'h090A0B0C);
    enq(32'h01020304);
    enq(32'h05060708);
    enq(32'h090A0B0C);
    run_drain(-1, 0, cyc, f_deq, f_val, vcyc);
    chk("stats_three_l", wc_l, 3);
    chk("stats_three_m", wc_m, 3);
    force dut_l.word_count_out = 16'hFFFF;
    #1;
    release dut_l.word_count_out;
    tick();
    push_word(32'h0F0E0D0C);
    enq(32'h0F0E0D0C);
    run_drain(-1, 0, cyc, f_deq, f_val, vcyc);
    chk("stats_wrap", wc_l, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
